uifdma_arb2: RTL and testbench

Two-channel FDMA arbiter: lets two frame-buffer engines (two `uidbuf` instances, or one video path plus a CPU-side mover) share a single FDMA master. Write and read directions are arbitrated independently, each with round-robin fairness and a request-acceptance watchdog. It sits between the requesters' FDMA ports and the one FDMA/AXI master. The selected channel's address, size and data pass through; busy, valid and ready are steered back only to the granted channel.

---
 rtl/uifdma_arb2.sv | 206 ++++++++++++++++++++
 tb/tb_uifdma_arb2.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uifdma_arb2.sv
// Two-channel FDMA arbiter: independent round-robin write/read arbitration
// with per-direction request watchdog, sharing one FDMA master.

module uifdma_arb2_dir #(
  parameter int unsigned AW          = 32,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic [2*AW-1:0] addr,
  input  logic [31:0]     size,
  input  logic            m_busy,
  output logic            m_areq,
  output logic [AW-1:0]   m_addr,
  output logic [15:0]     m_size,
  output logic [1:0]      grant,
  output logic            err,
  output logic            xfer_c
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic            busy_q;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            areq_d, err_d, win;
  logic [AW-1:0]   addr_d;
  logic [15:0]     size_d;
  logic [1:0]      grant_d;

  assign xfer_c = (state_q == S_XFER);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      m_areq  <= 1'b0;
      m_addr  <= '0;
      m_size  <= '0;
      grant   <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      busy_q  <= m_busy;
      cnt_q   <= cnt_d;
      m_areq  <= areq_d;
      m_addr  <= addr_d;
      m_size  <= size_d;
      grant   <= grant_d;
      err     <= err_d;
    end
  end

  // Next state: tie goes to the channel that did not own the last transfer
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = '0;
    areq_d  = m_areq;
    addr_d  = m_addr;
    size_d  = m_size;
    grant_d = grant;
    err_d   = err;
    win     = (req == 2'b11) ? ~last_q : req[1];
    cnt_inc = (cnt_q == CW'(ACK_TIMEOUT)) ? cnt_q : cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d = S_REQ;
          areq_d  = 1'b1;
          grant_d = win ? 2'b10 : 2'b01;
          addr_d  = win ? addr[AW +: AW] : addr[0 +: AW];
          size_d  = win ? size[31:16] : size[15:0];
        end
      end
      S_REQ: begin
        if (m_busy) begin
          state_d = S_XFER;
          areq_d  = 1'b0;
        end else if (cnt_inc == CW'(ACK_TIMEOUT)) begin
          state_d = S_IDLE;
          areq_d  = 1'b0;
          err_d   = 1'b1;
          last_d  = grant[1];
          grant_d = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_XFER: begin
        if (busy_q && !m_busy) begin
          state_d = S_IDLE;
          last_d  = grant[1];
          grant_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        areq_d  = 1'b0;
        grant_d = '0;
      end
    endcase
  end

endmodule

module uifdma_arb2 #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 128,
  parameter int unsigned ACK_TIMEOUT    = 1024
) (
  input  logic                        ui_clk,
  input  logic                        ui_rstn,
  input  logic [1:0]                  s_wareq,
  input  logic [2*AXI_ADDR_WIDTH-1:0] s_waddr,
  input  logic [31:0]                 s_wsize,
  output logic [1:0]                  s_wbusy,
  input  logic [2*AXI_DATA_WIDTH-1:0] s_wdata,
  output logic [1:0]                  s_wvalid,
  input  logic [1:0]                  s_wready,
  input  logic [1:0]                  s_rareq,
  input  logic [2*AXI_ADDR_WIDTH-1:0] s_raddr,
  input  logic [31:0]                 s_rsize,
  output logic [1:0]                  s_rbusy,
  output logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]                  s_rvalid,
  input  logic [1:0]                  s_rready,
  output logic [AXI_ADDR_WIDTH-1:0]   fdma_waddr,
  output logic                        fdma_wareq,
  output logic [15:0]                 fdma_wsize,
  input  logic                        fdma_wbusy,
  output logic [AXI_DATA_WIDTH-1:0]   fdma_wdata,
  input  logic                        fdma_wvalid,
  output logic                        fdma_wready,
  output logic [AXI_ADDR_WIDTH-1:0]   fdma_raddr,
  output logic                        fdma_rareq,
  output logic [15:0]                 fdma_rsize,
  input  logic                        fdma_rbusy,
  input  logic [AXI_DATA_WIDTH-1:0]   fdma_rdata,
  input  logic                        fdma_rvalid,
  output logic                        fdma_rready,
  output logic [1:0]                  wgrant,
  output logic [1:0]                  rgrant,
  output logic                        werr,
  output logic                        rerr
);

  localparam int unsigned DW = AXI_DATA_WIDTH;

  logic wxfer_c, rxfer_c;

  uifdma_arb2_dir #(.AW(AXI_ADDR_WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT)) u_warb (
    .clk    (ui_clk),
    .rst_n  (ui_rstn),
    .req    (s_wareq),
    .addr   (s_waddr),
    .size   (s_wsize),
    .m_busy (fdma_wbusy),
    .m_areq (fdma_wareq),
    .m_addr (fdma_waddr),
    .m_size (fdma_wsize),
    .grant  (wgrant),
    .err    (werr),
    .xfer_c (wxfer_c)
  );

  uifdma_arb2_dir #(.AW(AXI_ADDR_WIDTH), .ACK_TIMEOUT(ACK_TIMEOUT)) u_rarb (
    .clk    (ui_clk),
    .rst_n  (ui_rstn),
    .req    (s_rareq),
    .addr   (s_raddr),
    .size   (s_rsize),
    .m_busy (fdma_rbusy),
    .m_areq (fdma_rareq),
    .m_addr (fdma_raddr),
    .m_size (fdma_rsize),
    .grant  (rgrant),
    .err    (rerr),
    .xfer_c (rxfer_c)
  );

  assign s_wbusy = wgrant;
  assign s_rbusy = rgrant;

  // Data-phase steering straight from the grant register
  assign s_wvalid    = wxfer_c ? (wgrant & {2{fdma_wvalid}}) : 2'b00;
  assign fdma_wready = wxfer_c & |(wgrant & s_wready);
  assign s_rvalid    = rxfer_c ? (rgrant & {2{fdma_rvalid}}) : 2'b00;
  assign fdma_rready = rxfer_c & |(rgrant & s_rready);
  assign s_rdata     = fdma_rdata;

  always_comb begin
    fdma_wdata = '0;
    if (wgrant[1])      fdma_wdata = s_wdata[DW +: DW];
    else if (wgrant[0]) fdma_wdata = s_wdata[0 +: DW];
  end

endmodule

// File: tb/tb_uifdma_arb2.sv
// Self-checking bench for uifdma_arb2: randomized traffic against a
// transaction-level round-robin model.

module tb_uifdma_arb2;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 128;
  localparam int unsigned ACK = 8;

  logic            ui_clk = 1'b0;
  logic            ui_rstn = 1'b0;
  logic [1:0]      s_wareq = '0, s_rareq = '0;
  logic [2*AW-1:0] s_waddr = '0, s_raddr = '0;
  logic [31:0]     s_wsize = '0, s_rsize = '0;
  logic [1:0]      s_wbusy, s_rbusy, s_wvalid, s_rvalid;
  logic [2*DW-1:0] s_wdata = '0;
  logic [1:0]      s_wready = '0, s_rready = '0;
  logic [DW-1:0]   s_rdata;
  logic [AW-1:0]   fdma_waddr, fdma_raddr;
  logic            fdma_wareq, fdma_rareq;
  logic [15:0]     fdma_wsize, fdma_rsize;
  logic            fdma_wbusy = 1'b0, fdma_rbusy = 1'b0;
  logic [DW-1:0]   fdma_wdata;
  logic [DW-1:0]   fdma_rdata = '0;
  logic            fdma_wvalid = 1'b0, fdma_rvalid = 1'b0;
  logic            fdma_wready, fdma_rready;
  logic [1:0]      wgrant, rgrant;
  logic            werr, rerr;

  int total = 0;
  int bad   = 0;
  bit last_w, last_r;

  uifdma_arb2 #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .ACK_TIMEOUT(ACK)) dut (
    .ui_clk(ui_clk), .ui_rstn(ui_rstn),
    .s_wareq(s_wareq), .s_waddr(s_waddr), .s_wsize(s_wsize), .s_wbusy(s_wbusy),
    .s_wdata(s_wdata), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_rareq(s_rareq), .s_raddr(s_raddr), .s_rsize(s_rsize), .s_rbusy(s_rbusy),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .fdma_waddr(fdma_waddr), .fdma_wareq(fdma_wareq), .fdma_wsize(fdma_wsize),
    .fdma_wbusy(fdma_wbusy), .fdma_wdata(fdma_wdata), .fdma_wvalid(fdma_wvalid),
    .fdma_wready(fdma_wready),
    .fdma_raddr(fdma_raddr), .fdma_rareq(fdma_rareq), .fdma_rsize(fdma_rsize),
    .fdma_rbusy(fdma_rbusy), .fdma_rdata(fdma_rdata), .fdma_rvalid(fdma_rvalid),
    .fdma_rready(fdma_rready),
    .wgrant(wgrant), .rgrant(rgrant), .werr(werr), .rerr(rerr)
  );

  always #5 ui_clk = ~ui_clk;

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_dw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Round-robin rule: lone requester wins; on a tie the non-last channel wins
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input bit last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  function automatic int nz_outs();
    return $countones({s_wbusy, s_rbusy, s_wvalid, s_rvalid, wgrant, rgrant,
                       fdma_wareq, fdma_rareq, werr, rerr, fdma_wready, fdma_rready,
                       fdma_waddr, fdma_raddr, fdma_wsize, fdma_rsize,
                       fdma_wdata, s_rdata});
  endfunction

  task automatic clear_inputs();
    s_wareq = '0; s_rareq = '0; s_wready = '0; s_rready = '0;
    fdma_wbusy = 1'b0; fdma_rbusy = 1'b0; fdma_wvalid = 1'b0; fdma_rvalid = 1'b0;
    fdma_rdata = '0; s_wdata = '0;
  endtask

  task automatic do_reset();
    ui_rstn = 1'b0;
    clear_inputs();
    tick();
    tick();
    ui_rstn = 1'b1;
    last_w = 1'b1;
    last_r = 1'b1;
  endtask

  task automatic test_reset();
    ui_rstn = 1'b0;
    clear_inputs();
    #1;
    total++;
    if (nz_outs() !== 0) begin
      bad++; $display("FAIL reset_outs: nonzero bits=%0d want 0", nz_outs());
    end
    tick();
    ui_rstn = 1'b1;
    last_w = 1'b1; last_r = 1'b1;
    tick();
    total++;
    if ({wgrant, rgrant, fdma_wareq, fdma_rareq} !== 6'b0) begin
      bad++; $display("FAIL reset_idle: grants=%b%b areq=%b%b want 0", wgrant, rgrant, fdma_wareq, fdma_rareq);
    end
  endtask

  task automatic test_single();
    int holdbad = 0;
    s_waddr = {$urandom, 32'h1000_0000};
    s_wsize = {16'($urandom), 16'd480};
    s_wareq = 2'b01;
    tick();
    total++;
    if (wgrant !== 2'b01 || fdma_wareq !== 1'b1 || s_wbusy !== 2'b01) begin
      bad++; $display("FAIL single_grant: grant=%b areq=%b busy=%b want 01/1/01", wgrant, fdma_wareq, s_wbusy);
    end
    total++;
    if (fdma_waddr !== 32'h1000_0000 || fdma_wsize !== 16'd480) begin
      bad++; $display("FAIL single_addr: addr=%h size=%0d want 10000000/480", fdma_waddr, fdma_wsize);
    end
    fdma_wbusy = 1'b1;
    s_wareq = 2'b00;
    tick();
    total++;
    if (fdma_wareq !== 1'b0 || s_wbusy !== 2'b01) begin
      bad++; $display("FAIL single_ack: areq=%b busy=%b want 0/01", fdma_wareq, s_wbusy);
    end
    repeat (59) begin
      tick();
      if (s_wbusy !== 2'b01) holdbad++;
    end
    total++;
    if (holdbad !== 0) begin
      bad++; $display("FAIL single_hold: busy dropped in %0d cycles want 0", holdbad);
    end
    fdma_wbusy = 1'b0;
    tick();
    total++;
    if (s_wbusy !== 2'b00 || wgrant !== 2'b00) begin
      bad++; $display("FAIL single_done: busy=%b grant=%b want 00/00", s_wbusy, wgrant);
    end
    last_w = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [1:0]    exp;
    logic [AW-1:0] exp_addr;
    int n, dur, both = 0;
    do_reset();
    s_wareq = 2'b11;
    for (int k = 0; k < 4; k++) begin
      s_waddr = {$urandom, $urandom};
      s_wsize = $urandom;
      exp = rr_pick(2'b11, last_w);
      exp_addr = exp[1] ? s_waddr[AW +: AW] : s_waddr[0 +: AW];
      n = 0;
      while (wgrant === 2'b00 && n < 4) begin
        tick(); n++;
      end
      total++;
      if (n !== 1) begin
        bad++; $display("FAIL rr_gap%0d: grant after %0d cycles want 1", k, n);
      end
      total++;
      if (wgrant !== exp || fdma_waddr !== exp_addr) begin
        bad++; $display("FAIL rr_order%0d: grant=%b addr=%h want %b/%h", k, wgrant, fdma_waddr, exp, exp_addr);
      end
      fdma_wbusy = 1'b1;
      dur = $urandom_range(1, 6);
      repeat (dur + 1) begin
        tick();
        if (wgrant === 2'b11) both++;
      end
      fdma_wbusy = 1'b0;
      tick();
      total++;
      if (wgrant !== 2'b00) begin
        bad++; $display("FAIL rr_idle%0d: grant=%b want 00", k, wgrant);
      end
      last_w = exp[1];
    end
    total++;
    if (both !== 0) begin
      bad++; $display("FAIL rr_onehot: grant==11 in %0d cycles want 0", both);
    end
    s_wareq = 2'b00;
  endtask

  task automatic test_data_steering();
    logic [1:0] exp_v;
    do_reset();
    s_waddr = {$urandom, $urandom};
    s_wareq = 2'b10;
    tick();
    total++;
    if (wgrant !== 2'b10) begin
      bad++; $display("FAIL steer_grant: grant=%b want 10", wgrant);
    end
    s_wareq = 2'b00;
    fdma_wbusy = 1'b1;
    tick();
    for (int b = 0; b < 16; b++) begin
      s_wdata = {rnd_dw(), rnd_dw()};
      fdma_wvalid = 1'($urandom_range(0, 3) != 0);
      s_wready = 2'($urandom);
      exp_v = {fdma_wvalid, 1'b0};
      #1;
      total++;
      if (s_wvalid !== exp_v) begin
        bad++; $display("FAIL steer_valid%0d: s_wvalid=%b want %b", b, s_wvalid, exp_v);
      end
      total++;
      if (fdma_wdata !== s_wdata[DW +: DW]) begin
        bad++; $display("FAIL steer_data%0d: got %h want %h", b, fdma_wdata, s_wdata[DW +: DW]);
      end
      total++;
      if (fdma_wready !== s_wready[1]) begin
        bad++; $display("FAIL steer_ready%0d: got %b want %b", b, fdma_wready, s_wready[1]);
      end
      tick();
    end
    fdma_wvalid = 1'b0;
    fdma_wbusy = 1'b0;
    tick();
    total++;
    if (wgrant !== 2'b00 || s_wvalid !== 2'b00) begin
      bad++; $display("FAIL steer_end: grant=%b valid=%b want 00/00", wgrant, s_wvalid);
    end
  endtask

  task automatic test_independence();
    logic [1:0] exp_v;
    do_reset();
    s_wareq = 2'b01;
    tick();
    fdma_wbusy = 1'b1;
    s_wareq = 2'b00;
    tick();
    s_raddr = {$urandom, $urandom};
    s_rsize = $urandom;
    s_rareq = 2'b10;
    tick();
    total++;
    if (rgrant !== 2'b10 || fdma_rareq !== 1'b1 || wgrant !== 2'b01) begin
      bad++; $display("FAIL indep_grant: rgrant=%b rareq=%b wgrant=%b want 10/1/01", rgrant, fdma_rareq, wgrant);
    end
    total++;
    if (fdma_raddr !== s_raddr[AW +: AW] || fdma_rsize !== s_rsize[31:16]) begin
      bad++; $display("FAIL indep_addr: addr=%h size=%h want %h/%h", fdma_raddr, fdma_rsize, s_raddr[AW +: AW], s_rsize[31:16]);
    end
    s_rareq = 2'b00;
    fdma_rbusy = 1'b1;
    tick();
    for (int b = 0; b < 8; b++) begin
      fdma_rvalid = 1'($urandom);
      fdma_rdata = rnd_dw();
      s_rready = 2'($urandom);
      exp_v = {fdma_rvalid, 1'b0};
      #1;
      total++;
      if (s_rvalid !== exp_v || s_rdata !== fdma_rdata) begin
        bad++; $display("FAIL indep_rvalid%0d: s_rvalid=%b want %b data=%h want %h", b, s_rvalid, exp_v, s_rdata, fdma_rdata);
      end
      total++;
      if (fdma_rready !== s_rready[1]) begin
        bad++; $display("FAIL indep_rready%0d: got %b want %b", b, fdma_rready, s_rready[1]);
      end
      tick();
    end
    fdma_rvalid = 1'b0;
    fdma_rbusy = 1'b0;
    fdma_wbusy = 1'b0;
    tick();
    total++;
    if (rgrant !== 2'b00 || wgrant !== 2'b00) begin
      bad++; $display("FAIL indep_end: rgrant=%b wgrant=%b want 00/00", rgrant, wgrant);
    end
  endtask

  task automatic test_watchdog();
    int early = 0;
    logic [1:0] exp;
    do_reset();
    s_wareq = 2'b01;
    tick();
    total++;
    if (wgrant !== 2'b01) begin
      bad++; $display("FAIL wd_grant: grant=%b want 01", wgrant);
    end
    repeat (ACK - 1) begin
      tick();
      if (fdma_wareq !== 1'b1 || werr !== 1'b0) early++;
    end
    total++;
    if (early !== 0) begin
      bad++; $display("FAIL wd_early: aborted early in %0d cycles want 0", early);
    end
    s_wareq = 2'b11;
    tick();
    total++;
    if (werr !== 1'b1 || fdma_wareq !== 1'b0 || s_wbusy !== 2'b00 || wgrant !== 2'b00) begin
      bad++; $display("FAIL wd_fire: err=%b areq=%b busy=%b grant=%b want 1/0/00/00", werr, fdma_wareq, s_wbusy, wgrant);
    end
    last_w = 1'b0;
    exp = rr_pick(2'b11, last_w);
    tick();
    total++;
    if (wgrant !== exp || werr !== 1'b1 || rerr !== 1'b0) begin
      bad++; $display("FAIL wd_next: grant=%b err=%b rerr=%b want %b/1/0", wgrant, werr, rerr, exp);
    end
    s_wareq = 2'b00;
  endtask

  task automatic test_async_reset();
    do_reset();
    s_wareq = 2'b01;
    s_rareq = 2'b10;
    tick();
    fdma_wbusy = 1'b1;
    fdma_rbusy = 1'b1;
    tick();
    fdma_wvalid = 1'b1;
    s_wready = 2'b01;
    s_wdata = {rnd_dw(), rnd_dw()};
    #3;
    ui_rstn = 1'b0;
    fdma_wbusy = 1'b0; fdma_rbusy = 1'b0; fdma_wvalid = 1'b0; fdma_rdata = '0;
    #1;
    total++;
    if (nz_outs() !== 0) begin
      bad++; $display("FAIL arst_outs: nonzero bits=%0d want 0", nz_outs());
    end
    s_wareq = 2'b11;
    s_rareq = 2'b11;
    tick();
    ui_rstn = 1'b1;
    last_w = 1'b1; last_r = 1'b1;
    tick();
    total++;
    if (wgrant !== rr_pick(2'b11, last_w) || rgrant !== rr_pick(2'b11, last_r)) begin
      bad++; $display("FAIL arst_tie: wgrant=%b rgrant=%b want 01/01", wgrant, rgrant);
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_data_steering();
    test_independence();
    test_watchdog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
